// File: rtl/lsu_dbus_ctrl.sv
// Load-store unit: registers one load/store, drives the data bus and
// sequences the dual-port memory's read-modify-write store handshake.
module lsu_dbus_ctrl #(
  parameter logic [31:0] DMEM_BASE      = 32'h0000_0000,
  parameter int          DMEM_ADDR_BITS = 16,
  parameter int          TIMEOUT        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic        st_req,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic        lsu_busy,
  output logic        dbus_req,
  output logic        dbus_w_en,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_w_data,
  output logic [3:0]  dbus_sel_byte,
  output logic        dmem_sel,
  input  logic [31:0] dbus_r_data,
  input  logic        dbus_ack,
  input  logic        store_busy,
  output logic        lsu_valid,
  output logic [31:0] lsu_r_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_COMMIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic          dmem_q, dmem_d;
  logic          seen_q, seen_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;

  logic          f3_ok;
  logic          mis_in;
  logic          dsel_in;
  logic [3:0]    sel_in;
  logic [31:0]   wdata_in;
  logic [31:0]   byte_sh;
  logic [15:0]   half_v;
  logic [31:0]   ld_ext;
  logic          tmo;
  logic          st_done;

  always_comb begin
    f3_ok = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b000): f3_ok = 1'b1;
      (funct3 == 3'b001): f3_ok = 1'b1;
      (funct3 == 3'b010): f3_ok = 1'b1;
      (funct3 == 3'b100): f3_ok = !st_req;
      (funct3 == 3'b101): f3_ok = !st_req;
      default:            f3_ok = 1'b0;
    endcase
  end

  assign mis_in = ((funct3[1:0] == 2'b01) && addr_i[0])
               || ((funct3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  assign dsel_in = (addr_i[31:DMEM_ADDR_BITS]
                    == DMEM_BASE[31:DMEM_ADDR_BITS]);

  always_comb begin
    sel_in   = 4'b1111;
    wdata_in = st_data_i;
    case (funct3[1:0])
      2'b00: begin
        sel_in   = 4'b0001 << addr_i[1:0];
        wdata_in = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        sel_in   = 4'b0011 << {addr_i[1], 1'b0};
        wdata_in = {2{st_data_i[15:0]}};
      end
      default: begin
        sel_in   = 4'b1111;
        wdata_in = st_data_i;
      end
    endcase
  end

  // Lane extraction from the registered address, then extension
  assign byte_sh = dbus_r_data >> {addr_q[1:0], 3'b000};
  assign half_v  = addr_q[1] ? dbus_r_data[31:16] : dbus_r_data[15:0];

  always_comb begin
    ld_ext = dbus_r_data;
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_ext = {24'h0, byte_sh[7:0]};
      3'b001:  ld_ext = {{16{half_v[15]}}, half_v};
      3'b101:  ld_ext = {16'h0, half_v};
      default: ld_ext = dbus_r_data;
    endcase
  end

  assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
  assign st_done = dmem_q ? (seen_q && !store_busy) : dbus_ack;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    dmem_d  = dmem_q;
    seen_d  = seen_q | store_busy;
    cnt_d   = cnt_q + CW'(1);
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        seen_d  = 1'b0;
        rdata_d = '0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        if (ld_req || st_req) begin
          addr_d  = addr_i;
          f3_d    = funct3;
          wdata_d = wdata_in;
          sel_d   = sel_in;
          dmem_d  = dsel_in;
          if (!f3_ok) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (mis_in) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = st_req ? S_STORE : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (dbus_ack) begin
          rdata_d = ld_ext;
          state_d = S_RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_STORE: begin
        if (st_done) begin
          state_d = S_COMMIT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_COMMIT: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      dmem_q  <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      dmem_q  <= dmem_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  logic drive;
  logic st_drive;
  logic resp;

  assign drive    = (state_q == S_LOAD) || (state_q == S_STORE)
                 || (state_q == S_COMMIT);
  assign st_drive = (state_q == S_STORE) || (state_q == S_COMMIT);
  assign resp     = (state_q == S_RESP);

  assign lsu_busy      = drive;
  assign dbus_req      = (state_q == S_LOAD) || (state_q == S_STORE);
  assign dbus_w_en     = st_drive;
  assign dbus_addr     = drive ? addr_q : '0;
  assign dbus_w_data   = st_drive ? wdata_q : '0;
  assign dbus_sel_byte = drive ? sel_q : '0;
  assign dmem_sel      = dmem_q;
  assign lsu_valid     = resp;
  assign lsu_r_data    = resp ? rdata_q : '0;
  assign misalign      = resp && mis_q;
  assign bus_err       = resp && err_q;

endmodule

// File: doc/lsu_dbus_ctrl.md
Name: lsu_dbus_ctrl

Overview:
Load-store unit between the execute stage and the data bus / unified dual-port memory. It registers one load or store request and decodes the data-memory select. It drives byte-lane select and replicated write data, and sequences the memory's 3-cycle read-modify-write store handshake via store_busy. Load data is aligned and sign/zero-extended for writeback. Misaligned, illegal-width and timed-out accesses are flagged instead of being issued.

Parameters:
DMEM_BASE, 32'h0000_0000, base byte address of data memory region
DMEM_ADDR_BITS, 16, log2 of data memory region size in bytes; dmem_sel = (addr[31:DMEM_ADDR_BITS] == DMEM_BASE[31:DMEM_ADDR_BITS])
TIMEOUT, 16, max cycles in LOAD/STORE waiting for ack/completion before bus error (>=4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_req  in  1  load request from execute, sampled when lsu accepts
st_req  in  1  store request from execute
funct3  in  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
addr_i  in  32  byte address
st_data_i  in  32  store data, value in low bits
lsu_busy  out  1  stall to pipeline; high in LOAD, STORE, ST_COMMIT
dbus_req  out  1  bus request
dbus_w_en  out  1  1 = store
dbus_addr  out  32  registered byte address
dbus_w_data  out  32  lane-replicated store data
dbus_sel_byte  out  4  byte-lane enables
dmem_sel  out  1  data memory region select, registered with request
dbus_r_data  in  32  load data from bus (valid with dbus_ack)
dbus_ack  in  1  load ack / non-dmem store ack, same cycle as dbus_req
store_busy  in  1  memory store-in-progress indication
lsu_valid  out  1  one-cycle completion pulse (load or store)
lsu_r_data  out  32  extended load data, valid with lsu_valid; 0 for stores/errors
misalign  out  1  with lsu_valid: access misaligned, not issued
bus_err  out  1  with lsu_valid: illegal funct3 or timeout

Behaviour:
- Reset (async, any state): state IDLE, all outputs 0, timeout counter 0.
- States: IDLE, LOAD, STORE, ST_COMMIT, RESP. Request accepted only in IDLE or RESP. st_req has priority if both are high.
- Accept: latch addr, funct3, data, kind and dmem_sel. Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) -> RESP, misalign=1. Illegal funct3 -> RESP, bus_err=1. Otherwise -> LOAD or STORE.
- Lanes: B sel=0001<<addr[1:0], w_data={4{d[7:0]}}; H sel=0011<<{addr[1],1'b0}, w_data={2{d[15:0]}}; W sel=1111, w_data=d.
- LOAD: dbus_req=1, w_en=0. On dbus_ack, capture the extracted byte/half/word from dbus_r_data by lane and sign- or zero-extend it -> RESP. A dmem load acks in the same cycle, so total latency is accept+2 to lsu_valid.
- STORE: dbus_req=1, w_en=1; addr, sel and w_data held stable. seen_busy is set when store_busy=1.
  - dmem_sel=1: when seen_busy=1 and store_busy=0 (memory write cycle) -> ST_COMMIT. Req stays high through that write cycle; memory returns to idle regardless.
  - dmem_sel=0: dbus_ack -> ST_COMMIT.
- ST_COMMIT: dbus_req=0, outputs held -> RESP. The dmem store sequence is accept(c0), req c1-c3, commit c4, lsu_valid c5.
- RESP: lsu_valid=1 for exactly one cycle with the flags. A new request may be accepted in the same cycle; otherwise -> IDLE.
- Timeout: counter resets on entry to LOAD/STORE and increments each cycle there. On reaching TIMEOUT-1 without completion -> RESP, bus_err=1, dbus_req dropped, lsu_r_data=0.
- dbus_* outputs are 0 in IDLE and RESP. A reset mid-store aborts with no completion pulse.

Test Plan:
- Setup: mem[0x100]=32'h8070_F0A5. LB addr 0x101 -> lsu_valid 2 cycles after accept, lsu_r_data=32'hFFFF_FFF0. LBU 0x101 -> 32'h0000_00F0. LHU 0x102 -> 32'h0000_8070. LH 0x102 -> 32'hFFFF_8070.
- SB addr 0x103, data 0x11 to dmem -> dbus_sel_byte=1000, w_data=32'h1111_1111. dbus_req high exactly 3 cycles, lsu_busy 4 cycles, lsu_valid at accept+5. Then LW 0x100 -> 32'h1170_F0A5.
- LW addr 0x102 -> no dbus_req. misalign=1 with lsu_valid at accept+1. SH 0x101 -> same.
- Load to non-dmem address with dbus_ack never asserted, TIMEOUT=16 -> dbus_req high 16 cycles, then lsu_valid with bus_err=1, lsu_r_data=0. funct3=011 -> bus_err with no bus access.
- rst_n low during STORE cycle 2 -> all outputs 0 immediately. After release, state is IDLE and a subsequent LW completes normally. Simultaneous ld_req and st_req -> store performed.
